// File: rtl/mult_share_arbiter_pkg.sv
// Shared widths and helpers for the shared-multiplier arbiter.
// Operand/result widths match the external 11x8 signed multiplier.
package mult_pkg;

    localparam int N1_W         = 11;
    localparam int N2_W         = 8;
    localparam int RES_W        = 19;
    localparam int MULT_LAT_DEF = 8;

    // Never returns 0, so a 1-bit requester ID exists even for tiny configs.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side operand and response bundle.
// master = requesters, slave = arbiter.
interface mult_share_arbiter_if
    import mult_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*N1_W-1:0]  req_n1;
    logic [NUM_REQ*N2_W-1:0]  req_n2;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [NUM_REQ*RES_W-1:0] rsp_result;

    modport master (
        output req_valid, req_n1, req_n2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_n1, req_n2, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );

endinterface

// File: rtl/mult_share_arbiter_rsp_fifo.sv
// First-word fall-through FIFO; o_data is the head entry.
// Storage has no reset; only pointers and count clear.
module rsp_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= nxt(r_wr);
            if (w_pop)  r_rd <= nxt(r_rd);
            r_cnt <= r_cnt + CW'(i_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one fixed-latency multiplier; an ID pipe
// routes each product back, credits keep the response FIFOs from overflowing.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MULT_LAT  = MULT_LAT_DEF,
    parameter int RSP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mult_share_arbiter_if.slave bus,
    output logic [N1_W-1:0]     mult_n1,
    output logic [N2_W-1:0]     mult_n2,
    input  logic [RES_W-1:0]    mult_result,
    output logic [3:0]          inflight
);

    localparam int IW = clog2(NUM_REQ);
    localparam int PL = MULT_LAT + 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [IW-1:0]            r_ptr;
    logic [CW-1:0]            r_credit [NUM_REQ];
    logic [PL-1:0]            r_pv;
    logic [IW-1:0]            r_pid    [PL];
    logic [N1_W-1:0]          r_n1;
    logic [N2_W-1:0]          r_n2;
    logic [3:0]               r_inflight;
    logic [NUM_REQ-1:0]       w_elig;
    logic [NUM_REQ-1:0]       w_grant;
    logic [NUM_REQ-1:0]       w_push;
    logic [NUM_REQ-1:0]       w_pop;
    logic [NUM_REQ-1:0]       w_empty;
    logic [NUM_REQ-1:0]       w_full;
    logic [IW-1:0]            w_gid;
    logic [IW-1:0]            w_nptr;
    logic                     w_any;
    logic [NUM_REQ*RES_W-1:0] w_rsp;

    function automatic int rr_idx(input logic [IW-1:0] p, input int o);
        int k;
        k = int'(p) + o;
        return (k >= NUM_REQ) ? k - NUM_REQ : k;
    endfunction

    always_comb begin
        w_elig = '0;
        w_push = '0;
        w_pop  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = bus.req_valid[i] && (r_credit[i] != '0);
            w_push[i] = r_pv[PL-1] && (r_pid[PL-1] == IW'(i));
            w_pop[i]  = !w_empty[i] && bus.rsp_ready[i];
        end
    end

    always_comb begin
        w_grant = '0;
        w_gid   = '0;
        w_any   = 1'b0;
        for (int o = 0; o < NUM_REQ; o++) begin
            if (!w_any && w_elig[rr_idx(r_ptr, o)]) begin
                w_grant[rr_idx(r_ptr, o)] = 1'b1;
                w_gid = IW'(rr_idx(r_ptr, o));
                w_any = 1'b1;
            end
        end
    end

    assign w_nptr = (w_gid == IW'(NUM_REQ - 1)) ? '0 : w_gid + IW'(1);
    assign bus.req_ready = rst_n ? w_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_pv       <= '0;
            r_n1       <= '0;
            r_n2       <= '0;
            r_inflight <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_credit[i] <= CW'(RSP_DEPTH);
            for (int j = 0; j < PL; j++) r_pid[j] <= '0;
        end else begin
            if (w_any) r_ptr <= w_nptr;
            r_pv     <= {r_pv[PL-2:0], w_any};
            r_pid[0] <= w_gid;
            for (int j = 1; j < PL; j++) r_pid[j] <= r_pid[j-1];
            r_n1 <= w_any ? bus.req_n1[w_gid*N1_W +: N1_W] : '0;
            r_n2 <= w_any ? bus.req_n2[w_gid*N2_W +: N2_W] : '0;
            r_inflight <= r_inflight + 4'(w_any) - 4'(r_pv[PL-1]);
            for (int i = 0; i < NUM_REQ; i++)
                r_credit[i] <= r_credit[i] - CW'(w_grant[i]) + CW'(w_pop[i]);
        end
    end

    assign mult_n1  = r_n1;
    assign mult_n2  = r_n2;
    assign inflight = r_inflight;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        logic [RES_W-1:0] w_head;
        logic [CW-1:0]    w_cnt;

        rsp_fifo #(
            .WIDTH(RES_W),
            .DEPTH(RSP_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_push (w_push[g]),
            .i_data (mult_result),
            .i_pop  (w_pop[g]),
            .o_data (w_head),
            .o_full (w_full[g]),
            .o_empty(w_empty[g]),
            .o_count(w_cnt)
        );

        assign w_rsp[g*RES_W +: RES_W] = w_empty[g] ? '0 : w_head;

        // Credits bound occupancy, so pushing into a full FIFO is a bug.
        a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
            !(w_push[g] && w_full[g] && !w_pop[g]) &&
            (w_cnt <= CW'(RSP_DEPTH)));
    end

    assign bus.rsp_valid  = ~w_empty;
    assign bus.rsp_result = w_rsp;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with an 8-stage multiplier model.
// Expected products are queued at each handshake and popped on rsp handshakes.
module tb_mult_share_arbiter;
    import mult_pkg::*;

    localparam int NR  = 4;
    localparam int LAT = 8;
    localparam int DEP = 2;

    typedef struct {
        logic [10:0] n1;
        logic [7:0]  n2;
        int          exp;
        bit          lat;
    } vec_t;

    typedef struct {
        int exp;
        int edg;
        bit lat;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] mult_n1;
    logic [7:0]  mult_n2;
    logic [18:0] mult_result;
    logic [3:0]  inflight;

    logic signed [18:0] p [LAT];

    vec_t srcq [NR][$];
    sb_t  sbq  [NR][$];
    int   gcnt [NR];
    int   glog_id [$];
    int   glog_edge [$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    mult_share_arbiter_if #(.NUM_REQ(NR)) bus ();

    mult_share_arbiter #(
        .NUM_REQ  (NR),
        .MULT_LAT (LAT),
        .RSP_DEPTH(DEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .mult_n1    (mult_n1),
        .mult_n2    (mult_n2),
        .mult_result(mult_result),
        .inflight   (inflight)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External multiplier: no reset, fixed latency.
    always @(posedge clk) begin
        p[0] <= $signed(mult_n1) * $signed(mult_n2);
        for (int j = 1; j < LAT; j++) p[j] <= p[j-1];
    end
    assign mult_result = p[LAT-1];

    task automatic check(string nm, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        vec_t v;
        sb_t  e;
        int   act;
        for (int i = 0; i < NR; i++) begin
            act = int'($signed(bus.rsp_result[i*19 +: 19]));
            if (bus.rsp_valid[i]) begin
                if (sbq[i].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp%0d: got valid %0d expected none",
                             i, act);
                end else if (bus.rsp_ready[i]) begin
                    e = sbq[i].pop_front();
                    check($sformatf("rsp%0d", i), act, e.exp);
                    if (e.lat) check("latency", cyc - e.edg, 9);
                end
            end
            if (bus.req_valid[i] && bus.req_ready[i] && srcq[i].size() > 0) begin
                v = srcq[i].pop_front();
                sbq[i].push_back('{v.exp, cyc + 1, v.lat});
                gcnt[i]++;
                glog_id.push_back(i);
                glog_edge.push_back(cyc + 1);
            end
        end
    end

    task automatic add_vec(int r, int n1, int n2, int exp, bit lat = 1'b0);
        vec_t v;
        v.n1  = n1[10:0];
        v.n2  = n2[7:0];
        v.exp = exp;
        v.lat = lat;
        srcq[r].push_back(v);
    endtask

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            if (srcq[i].size() > 0) begin
                bus.req_valid[i]        = 1'b1;
                bus.req_n1[i*11 +: 11]  = srcq[i][0].n1;
                bus.req_n2[i*8 +: 8]    = srcq[i][0].n2;
            end else begin
                bus.req_valid[i]        = 1'b0;
                bus.req_n1[i*11 +: 11]  = '0;
                bus.req_n2[i*8 +: 8]    = '0;
            end
        end
    endtask

    task automatic step();
        apply();
        @(posedge clk);
        #1;
    endtask

    function automatic int busy();
        int n;
        n = 0;
        for (int i = 0; i < NR; i++) n += srcq[i].size() + sbq[i].size();
        return n;
    endfunction

    task automatic clr_cnt();
        for (int i = 0; i < NR; i++) gcnt[i] = 0;
        glog_id.delete();
        glog_edge.delete();
    endtask

    task automatic drain(string nm);
        int t;
        t = 0;
        while (busy() != 0 && t < 300) begin
            step();
            t++;
        end
        step();
        step();
        check({nm, "_drain"}, busy(), 0);
        check({nm, "_inflight0"}, int'(inflight), 0);
    endtask

    initial begin : seq
        bit seen;
        int t;
        bus.req_valid = '1;
        bus.req_n1    = '1;
        bus.req_n2    = '1;
        bus.rsp_ready = '1;
        for (int i = 0; i < NR; i++) gcnt[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", int'(bus.req_ready), 0);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_rsp_result0", int'(bus.rsp_result[18:0]), 0);
        check("rst_inflight", int'(inflight), 0);
        check("rst_mult_n1", int'(mult_n1), 0);
        check("rst_mult_n2", int'(mult_n2), 0);
        bus.req_valid = '0;
        bus.req_n1    = '0;
        bus.req_n2    = '0;
        rst_n = 1'b1;
        step();

        // Round-robin with all four requesters asking at once.
        clr_cnt();
        for (int k = 0; k < 2; k++) begin
            add_vec(0, 1, 1, 1);
            add_vec(1, 2, 2, 4);
            add_vec(2, 3, 3, 9);
            add_vec(3, 4, 4, 16);
        end
        repeat (12) step();
        check("rr_grants", glog_id.size(), 8);
        if (glog_id.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("rr_id%0d", k), glog_id[k], k % 4);
                check($sformatf("rr_edge%0d", k), glog_edge[k] - glog_edge[0], k);
            end
        end
        drain("rr");

        // Single product and its latency.
        clr_cnt();
        add_vec(0, 100, -3, -300, 1'b1);
        step();
        check("t1_mult_n1", int'(mult_n1), 100);
        check("t1_mult_n2", int'($signed(mult_n2)), -3);
        check("t1_inflight1", int'(inflight), 1);
        step();
        check("t1_mult_n1_idle", int'(mult_n1), 0);
        drain("t1");

        // Corner operands.
        add_vec(1, -1024, -128, 131072);
        add_vec(1, 0, -5, 0);
        add_vec(1, 1023, 127, 129921);
        add_vec(1, -1024, 127, -130048);
        drain("t4");

        // Credit backpressure on requester 2.
        clr_cnt();
        bus.rsp_ready = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            add_vec(0, 10 + k, 3, (10 + k) * 3);
            add_vec(1, -20 - k, 5, (-20 - k) * 5);
            add_vec(3, 7, -k, -7 * k);
        end
        for (int k = 0; k < 4; k++) add_vec(2, 30 + k, -2, -2 * (30 + k));
        repeat (40) step();
        check("bp_g2", gcnt[2], 2);
        check("bp_ready2", int'(bus.req_ready[2]), 0);
        check("bp_g0", gcnt[0], 6);
        check("bp_g1", gcnt[1], 6);
        check("bp_g3", gcnt[3], 6);
        bus.rsp_ready[2] = 1'b1;
        step();
        bus.rsp_ready[2] = 1'b0;
        repeat (5) step();
        check("bp_g2_pulse", gcnt[2], 3);
        bus.rsp_ready = '1;
        drain("t3");

        // Grant and pop on the same requester with one credit left.
        bus.rsp_ready[3] = 1'b0;
        add_vec(3, 7, 7, 49);
        t = 0;
        step();
        while (!bus.rsp_valid[3] && t < 20) begin
            step();
            t++;
        end
        check("t6_wait_timeout", int'(bus.rsp_valid[3]), 1);
        clr_cnt();
        add_vec(3, -8, 9, -72);
        add_vec(3, 5, -6, -30);
        add_vec(3, 2, 3, 6);
        bus.rsp_ready[3] = 1'b1;
        step();
        bus.rsp_ready[3] = 1'b0;
        repeat (4) step();
        check("t6_grants", gcnt[3], 2);
        bus.rsp_ready[3] = 1'b1;
        drain("t6");

        // Reset with products in flight.
        clr_cnt();
        add_vec(0, 1, 2, 2);
        add_vec(0, 3, 4, 12);
        add_vec(1, 5, 6, 30);
        add_vec(1, 7, 8, 56);
        add_vec(2, 9, 10, 90);
        repeat (5) step();
        check("t5_inflight5", int'(inflight), 5);
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) begin
            srcq[i].delete();
            sbq[i].delete();
        end
        apply();
        #1;
        check("t5_rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("t5_rst_inflight", int'(inflight), 0);
        repeat (2) step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            step();
            if (bus.rsp_valid != '0) seen = 1'b1;
        end
        check("t5_quiet", int'(seen), 0);
        clr_cnt();
        bus.rsp_ready[0] = 1'b0;
        add_vec(0, 11, 11, 121);
        add_vec(0, -12, 12, -144);
        add_vec(0, 13, -13, -169);
        repeat (6) step();
        check("t5_credit_g0", gcnt[0], 2);
        bus.rsp_ready = '1;
        drain("t5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
